// File: rtl/fir_pkg.sv
// Shared constants for the FIR stream engine: sizes, register offsets, ap_ctrl
// bit positions and the tap-address decode helpers.
package fir_pkg;

  localparam int NUM_TAPS = 11;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 12;
  localparam int IDX_W    = $clog2(NUM_TAPS);

  localparam logic [ADDR_W-1:0] AP_CTRL  = 12'h000;
  localparam logic [ADDR_W-1:0] DATA_LEN = 12'h010;
  localparam logic [ADDR_W-1:0] TAP_BASE = 12'h040;
  localparam logic [ADDR_W-1:0] TAP_END  = TAP_BASE + ADDR_W'(4 * NUM_TAPS);

  localparam int AP_START_BIT = 0;
  localparam int AP_DONE_BIT  = 1;
  localparam int AP_IDLE_BIT  = 2;

  typedef logic signed [DATA_W-1:0] word_t;

  // Taps sit on word-aligned addresses TAP_BASE + 4k.
  function automatic logic tap_hit(input logic [ADDR_W-1:0] addr);
    return (addr >= TAP_BASE) && (addr < TAP_END) && (addr[1:0] == 2'b00);
  endfunction

  function automatic logic [IDX_W-1:0] tap_index(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] off;
    off = (addr - TAP_BASE) >> 2;
    return off[IDX_W-1:0];
  endfunction

endpackage

// File: rtl/fir_mac_datapath.sv
// Sample history plus a single multiply-accumulate unit that walks the taps
// one per cycle, leaving y[n] in acc after NUM_TAPS enabled cycles.
module fir_mac_datapath
  import fir_pkg::*;
(
  input  logic  axis_clk,
  input  logic  axis_rst_n,
  input  logic  clear,
  input  logic  load,
  input  word_t sample,
  input  logic  mac_en,
  input  word_t taps [NUM_TAPS],
  output word_t acc,
  output logic  mac_last
);

  word_t            hist [NUM_TAPS];
  logic [IDX_W-1:0] tap_idx;

  // NOTE: the history is an array yet still reset, because a fresh run must
  // see all samples before its start as zero.
  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n || clear) begin
      for (int k = 0; k < NUM_TAPS; k++) hist[k] <= '0;
    end else if (load) begin
      hist[0] <= sample;
      for (int k = 1; k < NUM_TAPS; k++) hist[k] <= hist[k-1];
    end
  end

  assign mac_last = mac_en && (tap_idx == IDX_W'(NUM_TAPS - 1));

  // NOTE: non-blocking assignments keep acc and tap_idx updating from the
  // same pre-edge values regardless of statement order.
  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) begin
      tap_idx <= '0;
      acc     <= '0;
    end else if (load || clear) begin
      tap_idx <= '0;
      acc     <= '0;
    end else if (mac_en) begin
      acc     <= acc + taps[tap_idx] * hist[tap_idx];
      tap_idx <= mac_last ? '0 : tap_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/fir_stream_engine.sv
// FIR stream engine top: register port, run-control FSM and valid/ready
// stream handshakes around the sequential MAC datapath.
module fir_stream_engine
  import fir_pkg::*;
(
  input  logic              axis_clk,
  input  logic              axis_rst_n,
  input  logic              cfg_we,
  input  logic              cfg_re,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_wdata,
  output logic [DATA_W-1:0] cfg_rdata,
  output logic              cfg_rvalid,
  input  logic              ss_tvalid,
  input  logic [DATA_W-1:0] ss_tdata,
  input  logic              ss_tlast,
  output logic              ss_tready,
  output logic              sm_tvalid,
  output logic [DATA_W-1:0] sm_tdata,
  output logic              sm_tlast,
  input  logic              sm_tready
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAIT_IN = 3'd1;
  localparam logic [2:0] S_MAC     = 3'd2;
  localparam logic [2:0] S_OUT     = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]        state;
  word_t             taps [NUM_TAPS];
  logic [DATA_W-1:0] data_len;
  logic [DATA_W-1:0] out_cnt;
  logic              ap_done;
  logic              ap_idle;
  logic              start_go;
  logic              in_hs;
  logic              out_hs;
  logic              last_result;
  logic              mac_last;
  word_t             acc;
  logic [DATA_W-1:0] rdata_next;
  logic              unused_tlast;

  // ss_tlast is informational; completion is counted against data_length.
  assign unused_tlast = ss_tlast;

  assign ap_idle     = (state == S_IDLE) || (state == S_DONE);
  assign start_go    = cfg_we && (cfg_addr == AP_CTRL) && cfg_wdata[AP_START_BIT] && ap_idle;
  assign ss_tready   = (state == S_WAIT_IN);
  assign sm_tvalid   = (state == S_OUT);
  assign in_hs       = ss_tvalid && ss_tready;
  assign out_hs      = sm_tvalid && sm_tready;
  assign last_result = ((out_cnt + DATA_W'(1)) == data_len);
  assign sm_tlast    = sm_tvalid && last_result;
  assign sm_tdata    = acc;

  fir_mac_datapath u_mac (
    .axis_clk   (axis_clk),
    .axis_rst_n (axis_rst_n),
    .clear      (start_go),
    .load       (in_hs),
    .sample     (ss_tdata),
    .mac_en     (state == S_MAC),
    .taps       (taps),
    .acc        (acc),
    .mac_last   (mac_last)
  );

  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) begin
      state   <= S_IDLE;
      out_cnt <= '0;
      ap_done <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          // A zero-length run finishes on the spot and never leaves idle.
          if (start_go) state <= (data_len == '0) ? S_IDLE : S_WAIT_IN;
          else          state <= S_IDLE;
        end
        S_WAIT_IN: if (in_hs)    state <= S_MAC;
        S_MAC:     if (mac_last) state <= S_OUT;
        S_OUT:     if (out_hs)   state <= last_result ? S_DONE : S_WAIT_IN;
        default:                 state <= S_IDLE;
      endcase

      if (start_go)    out_cnt <= '0;
      else if (out_hs) out_cnt <= out_cnt + DATA_W'(1);

      // Setting done wins over the clear-on-read of the same cycle.
      if (start_go)                            ap_done <= (data_len == '0);
      else if (out_hs && last_result)          ap_done <= 1'b1;
      else if (cfg_re && (cfg_addr == AP_CTRL)) ap_done <= 1'b0;
    end
  end

  // Configuration is frozen while a run is in flight.
  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) begin
      data_len <= '0;
      for (int k = 0; k < NUM_TAPS; k++) taps[k] <= '0;
    end else if (cfg_we && ap_idle) begin
      if (cfg_addr == DATA_LEN) data_len <= cfg_wdata;
      if (tap_hit(cfg_addr))    taps[tap_index(cfg_addr)] <= cfg_wdata;
    end
  end

  // NOTE: rdata_next gets a default before any branch so no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    rdata_next = '0;
    if (cfg_addr == AP_CTRL) begin
      rdata_next[AP_START_BIT] = !ap_idle;
      rdata_next[AP_DONE_BIT]  = ap_done;
      rdata_next[AP_IDLE_BIT]  = ap_idle;
    end else if (cfg_addr == DATA_LEN) begin
      rdata_next = data_len;
    end else if (tap_hit(cfg_addr)) begin
      rdata_next = taps[tap_index(cfg_addr)];
    end
  end

  // Read data is captured from pre-write state, so a same-cycle write is not seen.
  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) begin
      cfg_rvalid <= 1'b0;
      cfg_rdata  <= '0;
    end else begin
      cfg_rvalid <= cfg_re;
      if (cfg_re) cfg_rdata <= rdata_next;
    end
  end

endmodule

// File: tb/tb_fir_stream_engine.sv
// Self-checking bench for fir_stream_engine: a direct-form FIR reference model
// feeds an expected-result queue that a single monitor compares every output against.
`timescale 1ns/1ps
module tb_fir_stream_engine;
  import fir_pkg::*;

  logic              axis_clk = 1'b0;
  logic              axis_rst_n;
  logic              cfg_we, cfg_re;
  logic [ADDR_W-1:0] cfg_addr;
  logic [DATA_W-1:0] cfg_wdata, cfg_rdata;
  logic              cfg_rvalid;
  logic              ss_tvalid, ss_tlast, ss_tready;
  logic [DATA_W-1:0] ss_tdata;
  logic              sm_tvalid, sm_tlast, sm_tready;
  logic [DATA_W-1:0] sm_tdata;

  fir_stream_engine dut (
    .axis_clk   (axis_clk),
    .axis_rst_n (axis_rst_n),
    .cfg_we     (cfg_we),
    .cfg_re     (cfg_re),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .cfg_rdata  (cfg_rdata),
    .cfg_rvalid (cfg_rvalid),
    .ss_tvalid  (ss_tvalid),
    .ss_tdata   (ss_tdata),
    .ss_tlast   (ss_tlast),
    .ss_tready  (ss_tready),
    .sm_tvalid  (sm_tvalid),
    .sm_tdata   (sm_tdata),
    .sm_tlast   (sm_tlast),
    .sm_tready  (sm_tready)
  );

  always #5 axis_clk = ~axis_clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  // Reference model: y[n] = sum tap[k]*x[n-k], samples before the run are zero.
  int tap_m [NUM_TAPS] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
  int xs [64];

  function automatic int fir_ref(input int n);
    int s = 0;
    for (int k = 0; k < NUM_TAPS; k++)
      if (n - k >= 0) s += tap_m[k] * xs[n - k];
    return s;
  endfunction

  int   exp_q [$];
  int   run_len  = 0;
  int   out_idx  = 0;
  int   got [64];
  bit   aborting = 0;
  bit   prev_stall = 0;
  logic [31:0] prev_data;

  // Monitor: every accepted result is checked against the model, and a stalled
  // result must hold its data until accepted.
  always @(negedge axis_clk) begin
    if (!axis_rst_n) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(sm_tvalid), 32'd1);
        check("hold_data", sm_tdata, prev_data);
      end
      prev_stall = 0;
      if (sm_tvalid) begin
        if (sm_tready) begin
          if (exp_q.size() == 0) begin
            check("extra_output", out_idx, run_len);
          end else begin
            int e;
            e = exp_q.pop_front();
            check($sformatf("y_data[%0d]", out_idx), sm_tdata, e);
            check($sformatf("y_last[%0d]", out_idx), 32'(sm_tlast), 32'(out_idx == run_len - 1));
            if (out_idx < 64) got[out_idx] = sm_tdata;
          end
          out_idx++;
        end else begin
          prev_stall = 1;
          prev_data  = sm_tdata;
        end
      end
    end
  end

  task automatic tick();
    @(posedge axis_clk);
    #1;
  endtask

  task automatic cfg_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    cfg_we = 1'b1; cfg_addr = addr; cfg_wdata = data;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic cfg_read(input logic [ADDR_W-1:0] addr, output logic [DATA_W-1:0] data);
    cfg_re = 1'b1; cfg_addr = addr;
    tick();
    cfg_re = 1'b0;
    check("rvalid", 32'(cfg_rvalid), 32'd1);
    data = cfg_rdata;
  endtask

  task automatic read_check(input string name, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] expected);
    logic [DATA_W-1:0] d;
    cfg_read(addr, d);
    check(name, d, expected);
  endtask

  // Returns one cycle after the edge on which the n-th result was accepted.
  task automatic wait_outs(input int n, output bit ok);
    ok = 0;
    for (int c = 0; c < 3000 && !aborting; c++) begin
      @(posedge axis_clk);
      if (out_idx >= n) begin ok = 1; break; end
    end
    #1;
  endtask

  task automatic feed(input int len);
    for (int i = 0; i < len && !aborting; i++) begin
      bit ok = 0;
      ss_tvalid = 1'b1; ss_tdata = xs[i]; ss_tlast = (i == len - 1);
      for (int c = 0; c < 200 && !aborting; c++) begin
        @(negedge axis_clk);
        if (ss_tready) begin ok = 1; break; end
      end
      if (!aborting) begin
        check($sformatf("in_accept[%0d]", i), 32'(ok), 32'd1);
        @(posedge axis_clk);
        #1;
      end
    end
    ss_tvalid = 1'b0; ss_tlast = 1'b0;
  endtask

  task automatic stall_ctl(input int stall_at);
    bit ok;
    if (stall_at >= 0) begin
      wait_outs(stall_at, ok);
      check("stall_reach", 32'(ok), 32'd1);
      sm_tready = 1'b0;
      ok = 0;
      for (int c = 0; c < 100; c++) begin
        @(negedge axis_clk);
        if (sm_tvalid) begin ok = 1; break; end
      end
      check("stall_valid_seen", 32'(ok), 32'd1);
      for (int i = 0; i < 20; i++) begin
        check("stall_ss_tready", 32'(ss_tready), 32'd0);
        @(negedge axis_clk);
      end
      @(posedge axis_clk);
      #1;
      sm_tready = 1'b1;
    end
  endtask

  task automatic ctl(input int len, input int busy_at, input int abort_at);
    bit ok;
    if (busy_at >= 0) begin
      wait_outs(busy_at, ok);
      read_check("busy_ap_ctrl", AP_CTRL, 32'h1);
      cfg_write(TAP_BASE, 32'd5);
      cfg_write(AP_CTRL, 32'd1);
    end
    if (abort_at >= 0) begin
      wait_outs(abort_at, ok);
      axis_rst_n = 1'b0;
      aborting   = 1;
      tick();
      check("rst_sm_tvalid", 32'(sm_tvalid), 32'd0);
      check("rst_sm_tlast", 32'(sm_tlast), 32'd0);
      check("rst_ss_tready", 32'(ss_tready), 32'd0);
      check("rst_rvalid", 32'(cfg_rvalid), 32'd0);
      check("rst_rdata", cfg_rdata, 32'd0);
      tick();
      axis_rst_n = 1'b1;
      tick();
      read_check("rst_ap_ctrl", AP_CTRL, 32'h4);
      read_check("rst_data_len", DATA_LEN, 32'd0);
      read_check("rst_tap5", TAP_BASE + 12'(4 * 5), 32'd0);
      check("rst_sm_tvalid_after", 32'(sm_tvalid), 32'd0);
    end else begin
      wait_outs(len, ok);
      check("run_complete", 32'(ok), 32'd1);
      check("done_ss_tready", 32'(ss_tready), 32'd0);
      check("done_sm_tvalid", 32'(sm_tvalid), 32'd0);
      read_check("done_ap_ctrl", AP_CTRL, 32'h6);
      read_check("done_cleared", AP_CTRL, 32'h4);
    end
  endtask

  task automatic run_stream(input int len, input int stall_at, input int busy_at, input int abort_at);
    exp_q.delete();
    for (int n = 0; n < len; n++) exp_q.push_back(fir_ref(n));
    run_len  = len;
    out_idx  = 0;
    aborting = 0;
    cfg_write(AP_CTRL, 32'd1);
    fork
      feed(len);
      stall_ctl(stall_at);
      ctl(len, busy_at, abort_at);
    join
  endtask

  initial begin
    logic [DATA_W-1:0] d;
    axis_rst_n = 1'b0;
    cfg_we = 1'b0; cfg_re = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    ss_tvalid = 1'b0; ss_tdata = '0; ss_tlast = 1'b0; sm_tready = 1'b1;
    for (int i = 0; i < 64; i++) xs[i] = i;
    repeat (3) tick();
    check("reset_sm_tvalid", 32'(sm_tvalid), 32'd0);
    check("reset_sm_tlast", 32'(sm_tlast), 32'd0);
    check("reset_ss_tready", 32'(ss_tready), 32'd0);
    check("reset_rvalid", 32'(cfg_rvalid), 32'd0);
    check("reset_rdata", cfg_rdata, 32'd0);
    axis_rst_n = 1'b1;
    tick();
    read_check("reset_ap_ctrl", AP_CTRL, 32'h4);
    read_check("reset_data_len", DATA_LEN, 32'd0);
    read_check("reset_tap3", TAP_BASE + 12'(4 * 3), 32'd0);

    // Pin the model to hand-derived values.
    check("model_y0", fir_ref(0), 32'd0);
    check("model_y1", fir_ref(1), 32'd0);
    check("model_y2", fir_ref(2), -32'sd10);
    check("model_y3", fir_ref(3), -32'sd29);
    check("model_y4", fir_ref(4), -32'sd25);
    check("model_y5", fir_ref(5), 32'd35);
    check("model_y10", fir_ref(10), 32'd915);
    check("model_y63", fir_ref(63), 32'd10614);

    // Configuration and readback.
    for (int k = 0; k < NUM_TAPS; k++) cfg_write(TAP_BASE + 12'(4 * k), tap_m[k]);
    cfg_write(DATA_LEN, 32'd64);
    cfg_write(12'h024, 32'hDEAD_BEEF);
    for (int k = 0; k < NUM_TAPS; k++)
      read_check($sformatf("tap_rb[%0d]", k), TAP_BASE + 12'(4 * k), tap_m[k]);
    read_check("len_rb", DATA_LEN, 32'd64);
    read_check("cfg_ap_ctrl", AP_CTRL, 32'h4);
    read_check("unmapped_24", 12'h024, 32'd0);
    read_check("unmapped_past_taps", TAP_END, 32'd0);

    // Same-cycle read and write returns the old value.
    cfg_we = 1'b1; cfg_re = 1'b1; cfg_addr = DATA_LEN; cfg_wdata = 32'd99;
    tick();
    cfg_we = 1'b0; cfg_re = 1'b0;
    check("rw_same_old", cfg_rdata, 32'd64);
    read_check("rw_same_new", DATA_LEN, 32'd99);

    // Zero-length run completes at once with no output.
    cfg_write(DATA_LEN, 32'd0);
    run_len = 0; out_idx = 0; exp_q.delete();
    cfg_write(AP_CTRL, 32'd1);
    check("len0_ss_tready", 32'(ss_tready), 32'd0);
    read_check("len0_ap_ctrl", AP_CTRL, 32'h6);
    repeat (20) tick();
    check("len0_no_output", out_idx, 32'd0);
    cfg_write(DATA_LEN, 32'd64);

    run_stream(64, -1, -1, -1);
    check("basic_y2", got[2], -32'sd10);
    check("basic_y10", got[10], 32'd915);
    check("basic_y63", got[63], 32'd10614);

    got[0] = 32'h1234; got[63] = 32'h1234;
    run_stream(64, -1, -1, -1);
    check("b2b_y0", got[0], 32'd0);
    check("b2b_y63", got[63], 32'd10614);

    run_stream(64, 7, -1, -1);
    check("bp_count", out_idx, 32'd64);

    run_stream(64, -1, 5, -1);
    read_check("busy_tap0", TAP_BASE, 32'd0);
    check("busy_count", out_idx, 32'd64);

    run_stream(64, -1, -1, 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/fir_stream_engine.md
Name: fir_stream_engine

Overview:
- 11-tap, 32-bit signed FIR accelerator placed in the user-project area of the SoC.
- Firmware configures the block through a simple register port: taps, data length and start.
- Firmware streams input samples in and reads filtered results out over valid/ready streams.
- Firmware mirrors results and handshake markers onto GPIO check bits, e.g. 16'hAB40 at test start and 16'hAB51 at test end.

Parameters:
- NUM_TAPS, 11, number of filter coefficients.
- DATA_W, 32, sample, tap and result width.
- ADDR_W, 12, register byte-address width.

Ports:
- axis_clk  in  1  single clock for all logic.
- axis_rst_n  in  1  synchronous, active-low reset.
- cfg_we  in  1  register write strobe, single cycle.
- cfg_re  in  1  register read strobe, single cycle.
- cfg_addr  in  ADDR_W  register byte address.
- cfg_wdata  in  DATA_W  write data.
- cfg_rdata  out  DATA_W  read data, valid when cfg_rvalid=1.
- cfg_rvalid  out  1  pulses one cycle after cfg_re.
- ss_tvalid  in  1  input sample valid.
- ss_tdata  in  DATA_W  input sample, signed.
- ss_tlast  in  1  last input marker; informational only, not used for completion.
- ss_tready  out  1  engine accepts an input sample.
- sm_tvalid  out  1  output result valid.
- sm_tdata  out  DATA_W  filtered result, signed.
- sm_tlast  out  1  asserted with the final result of a run.
- sm_tready  in  1  downstream accepts the result.

Behaviour:
- Register map:
  - 0x00 ap_ctrl: bit0 ap_start (W1, self-clears, reads 1 while the run is pending or active); bit1 ap_done (RO, cleared by reading 0x00); bit2 ap_idle (RO).
  - 0x10 data_length (R/W).
  - 0x40 + 4k tap[k], k = 0..10 (R/W).
  - Unmapped reads return 0; unmapped writes are ignored.
- Reset state:
  - ap_idle=1, ap_done=0, ap_start=0.
  - data_length=0, all taps=0, sample history=0.
  - ss_tready=0, sm_tvalid=0, sm_tlast=0, cfg_rvalid=0, cfg_rdata=0.
- Writes to taps or data_length while ap_idle=0 are ignored. Reads are always allowed.
- Writing ap_start=1 while idle:
  - next cycle: ap_idle=0, ap_done=0, history cleared, output counter=0.
  - ap_start=1 while busy is ignored.
- Per sample:
  - Engine raises ss_tready when waiting for a sample; handshake when ss_tvalid && ss_tready.
  - Sample shifts into history: x[n] newest.
  - Sequential MAC, one tap per cycle: y[n] = sum over k=0..10 of tap[k]*x[n-k]. Samples before the run start count as 0.
  - Products and sum are truncated to 32 bits (two's-complement wrap).
  - sm_tvalid rises no later than 13 cycles after the input handshake.
  - sm_tvalid and sm_tdata stay stable until sm_tready. No new sample is accepted until the result is taken.
- Completion:
  - When the data_length-th result handshakes, sm_tlast=1 is shown with that result.
  - The following cycle: ap_done=1, ap_idle=1, ss_tready=0.
- data_length=0: the run completes immediately (done/idle the cycle after start) and no output is produced.
- Reset asserted mid-run aborts the run; every register returns to its reset value.
- A cfg_re and cfg_we in the same cycle to the same address: the read returns the old value.

Decomposition:
- fir_pkg holds NUM_TAPS, DATA_W, the register offsets (AP_CTRL=0x00, DATA_LEN=0x10, TAP_BASE=0x40) and the ap_ctrl bit indices.
- One sub-module, fir_mac_datapath: history shift register, tap index counter, multiplier and accumulator.
- The top module keeps the register file, the control FSM and the stream handshakes.
- Control FSM states:
  - IDLE → (start) WAIT_IN.
  - WAIT_IN → (in handshake) MAC.
  - MAC → (after 11 taps) OUT.
  - OUT → (out handshake) WAIT_IN, or DONE when the count is reached.
  - DONE → IDLE.

Test Plan:
- Config readback: write taps {0,-10,-9,23,56,63,56,23,-9,-10,0} and data_length=64 → reads return the same values; ap_ctrl reads 0x4.
- Basic run: feed x[i]=i for i=0..63 → outputs y0=0, y1=0, y2=-10, y3=-29, y4=-25, y5=35, y10=915, y63=10614 (0x2976); sm_tlast only on y63; ap_done=1 afterwards.
- Back-to-back runs: repeat the run without reprogramming → identical 64 results, proving the history is cleared; reading ap_ctrl clears done.
- Backpressure: hold sm_tready=0 for 20 cycles on result 7 → data stays stable, ss_tready=0, no sample is lost.
- Busy protection: write tap[0]=5 mid-run → ignored, results unchanged; a second ap_start mid-run is ignored.
- Reset mid-run: assert axis_rst_n=0 after 10 outputs → all registers go to reset values, ap_idle=1, sm_tvalid=0.
